// File: rtl/quad_encoder_tx.sv
// quad_encoder_tx: rotary-encoder emulator. Accepts step commands over a
// valid/ready handshake and emits Gray-coded A/B edges every STEP_CYCLES
// clocks, while keeping a mirror of the position the decoder should reach.
//
// Build option: define QUAD_TX_BOUNCE_EN to add contact-bounce emulation on
// the line that changes at each edge (new/old/new/old/new over 5 cycles).
//
// state  | meaning
// IDLE   | ready for a command
// WAIT   | counting down to the next A/B edge
// DONE   | command finished, done pulse issued, then back to IDLE
module quad_encoder_tx #(
   parameter int unsigned STEP_CYCLES = 16,
   parameter int unsigned POS_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [7:0]       cmd_steps,
   output logic             enc_a,
   output logic             enc_b,
   output logic             busy,
   output logic             done,
   output logic [POS_W-1:0] position
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [7:0] TIMER_RELOAD = 8'(STEP_CYCLES - 1);

   if (STEP_CYCLES < 2 || STEP_CYCLES > 255) begin : g_bad_step
      $error("quad_encoder_tx: STEP_CYCLES must be in 2..255");
   end

`ifdef QUAD_TX_BOUNCE_EN
   // Bounce spans four cycles after the edge, so it must settle well before
   // the next edge can be scheduled.
   if (STEP_CYCLES < 8) begin : g_bad_bounce_step
      $error("quad_encoder_tx: STEP_CYCLES must be >= 8 with bounce emulation");
   end
`endif

   state_t           r_state;
   logic             r_dir;
   logic [7:0]       r_remaining;
   logic [7:0]       r_timer;
   logic [1:0]       r_phase;
   logic             r_enc_a;
   logic             r_enc_b;
   logic             r_busy;
   logic             r_done;
   logic [POS_W-1:0] r_pos;

   logic [1:0]       w_next_phase;
   logic [1:0]       w_next_ab;
   logic             w_accept;

   // Gray map from phase index to {A,B}.
   function automatic logic [1:0] ab_of(input logic [1:0] ph);
      logic [1:0] ab;
      case (ph)
         2'd0:    ab = 2'b00;
         2'd1:    ab = 2'b10;
         2'd2:    ab = 2'b11;
         default: ab = 2'b01;
      endcase
      return ab;
   endfunction

   assign w_next_phase = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
   assign w_next_ab    = ab_of(w_next_phase);
   assign cmd_ready    = (r_state == S_IDLE) && !reset;
   assign w_accept     = cmd_valid && cmd_ready;

`ifdef QUAD_TX_BOUNCE_EN
   logic [2:0] r_bnc_cnt;
   logic       r_bnc_a;
   logic [1:0] w_cur_ab;
   assign w_cur_ab = ab_of(r_phase);
`endif

   // Command sequencing, edge generation and position mirror.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_dir       <= 1'b0;
         r_remaining <= 8'd0;
         r_timer     <= 8'd0;
         r_phase     <= 2'd0;
         r_enc_a     <= 1'b0;
         r_enc_b     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pos       <= '0;
`ifdef QUAD_TX_BOUNCE_EN
         r_bnc_cnt   <= 3'd0;
         r_bnc_a     <= 1'b0;
`endif
      end else begin
`ifdef QUAD_TX_BOUNCE_EN
         // Each toggle alternates the changed line between old and new value.
         if (r_bnc_cnt != 3'd0) begin
            r_bnc_cnt <= r_bnc_cnt - 3'd1;
            if (r_bnc_a) r_enc_a <= ~r_enc_a;
            else         r_enc_b <= ~r_enc_b;
         end
`endif
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dir       <= cmd_dir;
                  r_remaining <= cmd_steps;
                  r_timer     <= TIMER_RELOAD;
                  if (cmd_steps == 8'd0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_WAIT;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (r_timer == 8'd0) begin
                  r_phase     <= w_next_phase;
                  r_enc_a     <= w_next_ab[1];
                  r_enc_b     <= w_next_ab[0];
                  r_pos       <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
                  r_remaining <= r_remaining - 8'd1;
`ifdef QUAD_TX_BOUNCE_EN
                  r_bnc_cnt   <= 3'd4;
                  r_bnc_a     <= w_cur_ab[1] ^ w_next_ab[1];
`endif
                  if (r_remaining == 8'd1) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_timer <= TIMER_RELOAD;
                  end
               end else begin
                  r_timer <= r_timer - 8'd1;
               end
            end
            S_DONE: begin
               // First cycle in DONE raises the pulse, second drops it.
               if (!r_done) begin
                  r_done <= 1'b1;
               end else begin
                  r_done  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign enc_a    = r_enc_a;
   assign enc_b    = r_enc_b;
   assign busy     = r_busy;
   assign done     = r_done;
   assign position = r_pos;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Bench for quad_encoder_tx: directed and random step commands against a
// cycle-offset model of the expected A/B, position, busy, done and ready,
// plus a loopback decoder on a second instance with a 64-cycle edge rate.
module tb_quad_encoder_tx;

`ifdef QUAD_TX_BOUNCE_EN
   localparam bit BOUNCE = 1'b1;
   localparam int SC     = 8;
`else
   localparam bit BOUNCE = 1'b0;
   localparam int SC     = 4;
`endif
   localparam int SC64 = 64;

   logic       clk;
   logic       reset, cmd_valid, cmd_ready, cmd_dir, enc_a, enc_b, busy, done;
   logic [7:0] cmd_steps, position;

   logic       b_reset, b_cmd_valid, b_cmd_ready, b_cmd_dir, b_enc_a, b_enc_b, b_busy, b_done;
   logic [7:0] b_cmd_steps, b_position;

   quad_encoder_tx #(.STEP_CYCLES(SC), .POS_W(8)) u_dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .enc_a(enc_a), .enc_b(enc_b),
      .busy(busy), .done(done), .position(position));

   quad_encoder_tx #(.STEP_CYCLES(SC64), .POS_W(8)) u_dut64 (
      .clk(clk), .reset(b_reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_dir(b_cmd_dir), .cmd_steps(b_cmd_steps), .enc_a(b_enc_a), .enc_b(b_enc_b),
      .busy(b_busy), .done(b_done), .position(b_position));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [1:0] ab_tbl [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   int m_phase = 0;
   int m_pos   = 0;

   function automatic int mod4(input int x);
      return ((x % 4) + 4) % 4;
   endfunction

   function automatic int idx_of(input logic [1:0] ab);
      int r;
      case (ab)
         2'b00:   r = 0;
         2'b10:   r = 1;
         2'b11:   r = 2;
         default: r = 3;
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Loopback decoder: counts Gray transitions on the 64-cycle instance.
   int dec_cnt = 0;
   int dec_err = 0;
   logic [1:0] dec_prev = 2'b00;
   always @(negedge clk) begin
      int delta;
      if (b_reset) begin
         dec_cnt  = 0;
         dec_prev = 2'b00;
      end else begin
         delta = mod4(idx_of({b_enc_a, b_enc_b}) - idx_of(dec_prev));
         if (delta == 1) dec_cnt++;
         else if (delta == 3) dec_cnt--;
         else if (delta == 2) dec_err++;
         dec_prev = {b_enc_a, b_enc_b};
      end
   end

   task automatic do_reset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_ab",    32'({enc_a, enc_b}), 32'd0);
      check("rst_pos",   32'(position), 32'd0);
      reset   = 1'b0;
      m_phase = 0;
      m_pos   = 0;
   endtask

   // Issue one command and check every cycle from the accept edge until the
   // block is idle again. With noise, random commands are offered while busy.
   task automatic run_cmd(input bit dir, input int n, input bit noise);
      int L;
      int e;
      int shown;
      L = n * SC;
      cmd_dir   = dir;
      cmd_steps = 8'(n);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      for (int d = 0; d <= L + 3; d++) begin
         e = d / SC;
         if (e > n) e = n;
         shown = mod4(m_phase + (dir ? e : -e));
         if (BOUNCE && e > 0 && ((d - e * SC) == 1 || (d - e * SC) == 3))
            shown = mod4(m_phase + (dir ? (e - 1) : -(e - 1)));
         check("ab",    32'({enc_a, enc_b}), 32'(ab_tbl[shown]));
         check("pos",   32'(position), 32'((m_pos + (dir ? e : -e)) & 255));
         check("busy",  32'(busy), 32'(n > 0 && d < L));
         check("done",  32'(done), 32'(d == L + 1));
         check("ready", 32'(cmd_ready), 32'(d >= L + 2));
         if (noise && d <= L + 1) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_dir   = 1'($urandom);
            cmd_steps = 8'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      m_phase = mod4(m_phase + (dir ? n : -n));
      m_pos   = (m_pos + (dir ? n : -n)) & 255;
   endtask

   initial begin
      int cyc;
      int done_seen;
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_dir     = 1'b0;
      cmd_steps   = 8'd0;
      b_reset     = 1'b1;
      b_cmd_valid = 1'b0;
      b_cmd_dir   = 1'b0;
      b_cmd_steps = 8'd0;

      // Reset and idle.
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready_hi", 32'(cmd_ready), 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_done",     32'(done), 32'd0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("idle_ab",    32'({enc_a, enc_b}), 32'd0);
         check("idle_pos",   32'(position), 32'd0);
         check("idle_busy",  32'(busy), 32'd0);
         check("idle_done",  32'(done), 32'd0);
         check("idle_ready", 32'(cmd_ready), 32'd1);
      end

      // Forward 4 steps: 10, 11, 01, 00.
      run_cmd(1'b1, 4, 1'b0);
      check("fwd4_pos", 32'(position), 32'd4);

      // Reverse 3 from zero wraps to 253, then forward 3 back to zero.
      do_reset();
      run_cmd(1'b0, 3, 1'b0);
      check("rev3_pos", 32'(position), 32'd253);
      run_cmd(1'b1, 3, 1'b0);
      check("fwd3_pos", 32'(position), 32'd0);

      // Zero-step command.
      run_cmd(1'b1, 0, 1'b0);

      // Commands offered while busy must be ignored.
      run_cmd(1'b1, 5, 1'b1);
      run_cmd(1'b0, 2, 1'b1);

      // Random commands.
      for (int i = 0; i < 30; i++)
         run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));

      // Maximum step count in both directions.
      run_cmd(1'b1, 255, 1'b0);
      run_cmd(1'b0, 255, 1'b1);

      // Loopback on the 64-cycle instance: 40 forward steps.
      b_reset = 1'b0;
      @(posedge clk);
      #1;
      b_cmd_dir   = 1'b1;
      b_cmd_steps = 8'd40;
      b_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      b_cmd_valid = 1'b0;
      cyc = 0;
      while (!b_done && cyc < 40 * SC64 + 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("lb_done_seen", 32'(b_done), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      check("lb_pos",       32'(b_position), 32'd40);
      check("lb_dec_cnt",   32'(dec_cnt), 32'd40);
      check("lb_dec_match", 32'(dec_cnt & 255), 32'(b_position));
      check("lb_dec_err",   32'(dec_err), 32'd0);

      // Reset in the middle of a command, after reaching phase 2 (AB=11).
      b_cmd_dir   = 1'b1;
      b_cmd_steps = 8'd6;
      b_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      b_cmd_valid = 1'b0;
      repeat (2 * SC64 + 2) @(posedge clk);
      #1;
      check("mid_ab_before", 32'({b_enc_a, b_enc_b}), 32'b11);
      check("mid_busy",      32'(b_busy), 32'd1);
      b_reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_ab_after",  32'({b_enc_a, b_enc_b}), 32'd0);
      check("mid_pos_after", 32'(b_position), 32'd0);
      check("mid_busy_after", 32'(b_busy), 32'd0);
      check("mid_ready_rst", 32'(b_cmd_ready), 32'd0);
      b_reset   = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 5 * SC64; i++) begin
         @(posedge clk);
         #1;
         if (b_done || b_enc_a || b_enc_b) done_seen++;
      end
      check("mid_no_done_no_edge", 32'(done_seen), 32'd0);
      check("mid_ready_idle",      32'(b_cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
